// File: rtl/rx_fifo.sv
// ============================================================================
// Module   : rx_fifo
// Purpose  : UART receive FIFO. Entries carry a framing-error tag, the head
//            entry is always visible on the outputs, and the block reports
//            full, empty, overrun, fill-level and idle-timeout status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_fifo #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 8,
  parameter int THRESH  = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     fe_in,
  input  logic                     pop,
  input  logic                     clr_ovr,
  output logic [WIDTH-1:0]         data_out,
  output logic                     fe_out,
  output logic                     rxff,
  output logic                     rxfe,
  output logic                     ovr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rx_int,
  output logic                     rx_tmo
);

  localparam int                C_AW   = $clog2(DEPTH);
  localparam int                C_TW   = $clog2(TIMEOUT + 1);
  localparam logic [C_AW:0]     C_FULL = (C_AW + 1)'(DEPTH);
  localparam logic [C_AW:0]     C_THR  = (C_AW + 1)'(THRESH);
  localparam logic [C_TW-1:0]   C_TMO  = C_TW'(TIMEOUT);

  logic [WIDTH:0]    r_mem [DEPTH];
  logic [C_AW-1:0]   r_wr_ptr;
  logic [C_AW-1:0]   r_rd_ptr;
  logic [C_AW:0]     r_count;
  logic              r_ovr;
  logic [C_TW-1:0]   r_idle;
  logic              r_tmo;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [C_TW-1:0]   w_idle_nxt;
  logic [WIDTH:0]    w_head;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = en & pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_push  = en & push & (~w_full | w_pop);
  assign w_drop  = en & push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {fe_in, data_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (C_AW + 1)'(1);
        2'b01:   r_count <= r_count - (C_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear when both happen on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end else if (clr_ovr) begin
      r_ovr <= 1'b0;
    end
  end

  always_comb begin
    w_idle_nxt = r_idle;
    if (w_push || w_pop || w_empty) begin
      w_idle_nxt = '0;
    end else if (en && (r_idle != C_TMO)) begin
      w_idle_nxt = r_idle + C_TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_idle <= w_idle_nxt;
      r_tmo  <= (w_idle_nxt == C_TMO);
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign data_out = w_empty ? '0 : w_head[WIDTH-1:0];
  assign fe_out   = w_empty ? 1'b0 : w_head[WIDTH];
  assign rxff     = w_full;
  assign rxfe     = w_empty;
  assign ovr      = r_ovr;
  assign count    = r_count;
  assign rx_int   = (r_count >= C_THR);
  assign rx_tmo   = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo.sv
// ============================================================================
// Module   : tb_rx_fifo
// Purpose  : Directed self-checking bench for rx_fifo with default parameters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_fifo;

  logic       clk;
  logic       reset;
  logic       en;
  logic       push;
  logic [7:0] data_in;
  logic       fe_in;
  logic       pop;
  logic       clr_ovr;
  logic [7:0] data_out;
  logic       fe_out;
  logic       rxff;
  logic       rxfe;
  logic       ovr;
  logic [3:0] count;
  logic       rx_int;
  logic       rx_tmo;

  int n_checks = 0;
  int n_errors = 0;

  rx_fifo #(.DEPTH(8), .WIDTH(8), .THRESH(4), .TIMEOUT(32)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .push     (push),
    .data_in  (data_in),
    .fe_in    (fe_in),
    .pop      (pop),
    .clr_ovr  (clr_ovr),
    .data_out (data_out),
    .fe_out   (fe_out),
    .rxff     (rxff),
    .rxfe     (rxfe),
    .ovr      (ovr),
    .count    (count),
    .rx_int   (rx_int),
    .rx_tmo   (rx_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive strobes, take the edge, then release strobes 1ns later.
  task automatic cyc(input logic p, input logic [7:0] d, input logic f, input logic po);
    push    = p;
    data_in = d;
    fe_in   = f;
    pop     = po;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    fe_in   = 1'b0;
    clr_ovr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_q [$];
    reset = 1'b0; en = 1'b1; push = 1'b0; data_in = '0;
    fe_in = 1'b0; pop = 1'b0; clr_ovr = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_rxfe", rxfe, 1);
    check("rst_rxff", rxff, 0);
    check("rst_int", rx_int, 0);
    check("rst_data", data_out, 0);
    check("rst_fe", fe_out, 0);
    check("rst_ovr", ovr, 0);
    check("rst_tmo", rx_tmo, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic ordering
    cyc(1, 8'h24, 0, 0); cyc(1, 8'h32, 0, 0); cyc(1, 8'h63, 0, 0);
    check("t1_count", count, 3);
    check("t1_head", data_out, 8'h24);
    check("t1_rxfe", rxfe, 0);
    check("t1_int", rx_int, 0);
    exp_q = '{8'h24, 8'h32, 8'h63};
    foreach (exp_q[i]) begin
      check("t1_pop_data", data_out, exp_q[i]);
      cyc(0, 0, 0, 1);
    end
    check("t1_empty", rxfe, 1);
    check("t1_data0", data_out, 0);

    // Fill, threshold, overrun
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'h10 + 8'(i), 0, 0);
      check("t2_int", rx_int, (i >= 3) ? 1 : 0);
      check("t2_count", count, i + 1);
    end
    check("t2_full", rxff, 1);
    cyc(1, 8'hAA, 0, 0);
    check("t2_ovr", ovr, 1);
    check("t2_ovr_count", count, 8);
    check("t2_ovr_head", data_out, 8'h10);
    cyc(0, 0, 0, 1);
    check("t2_after_pop", data_out, 8'h11);
    check("t2_after_pop_cnt", count, 7);
    check("t2_ovr_sticky", ovr, 1);
    en = 1'b0; clr_ovr = 1'b1;
    cyc(0, 0, 0, 0);
    en = 1'b1;
    check("t2_clr_ovr", ovr, 0);

    // Simultaneous push/pop when full, pointer wrap
    cyc(1, 8'h18, 0, 0);
    check("t3_full", rxff, 1);
    cyc(1, 8'h55, 0, 1);
    check("t3_cnt", count, 8);
    check("t3_no_ovr", ovr, 0);
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
    foreach (exp_q[i]) begin
      check("t3_pop_data", data_out, exp_q[i]);
      cyc(0, 0, 0, 1);
    end
    check("t3_empty", rxfe, 1);

    // Push + pop while empty
    cyc(1, 8'h3C, 0, 1);
    check("t4_cnt", count, 1);
    check("t4_data", data_out, 8'h3C);
    cyc(0, 0, 0, 1);
    check("t4_empty", rxfe, 1);

    // Framing-error tag
    cyc(1, 8'h81, 1, 0); cyc(1, 8'h82, 0, 0);
    check("t5_data", data_out, 8'h81);
    check("t5_fe1", fe_out, 1);
    cyc(0, 0, 0, 1);
    check("t5_data2", data_out, 8'h82);
    check("t5_fe0", fe_out, 0);
    cyc(0, 0, 0, 1);
    check("t5_empty", rxfe, 1);

    // Idle timeout and clear by pop
    cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0);
    idle(31);
    check("t6_tmo_early", rx_tmo, 0);
    idle(1);
    check("t6_tmo", rx_tmo, 1);
    idle(3);
    check("t6_tmo_hold", rx_tmo, 1);
    cyc(0, 0, 0, 1);
    check("t6_tmo_clr", rx_tmo, 0);
    check("t6_cnt", count, 1);
    idle(32);
    check("t6_tmo2", rx_tmo, 1);
    // Asynchronous reset between edges
    #3 reset = 1'b0;
    #1;
    check("t6_arst_cnt", count, 0);
    check("t6_arst_tmo", rx_tmo, 0);
    check("t6_arst_rxfe", rxfe, 1);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Enable gating freezes traffic and idle counter
    cyc(1, 8'h07, 0, 0);
    idle(10);
    en = 1'b0;
    for (int i = 0; i < 30; i++) cyc(1, 8'hEE, 0, 1);
    check("t7_cnt", count, 1);
    check("t7_data", data_out, 8'h07);
    check("t7_tmo_frozen", rx_tmo, 0);
    check("t7_ovr", ovr, 0);
    en = 1'b1;
    idle(21);
    check("t7_tmo_early", rx_tmo, 0);
    idle(1);
    check("t7_tmo", rx_tmo, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
Receive-side byte buffer for the single-cycle UART. It sits between the UART receiver's deserialiser and the CPU read port, and is the counterpart of the transmit FIFO. It accepts one received byte per push together with a framing-error tag, and presents the oldest entry first-word-fall-through. It reports full, empty, overrun, a fill-level interrupt and an idle timeout to the UART status register.

Parameters:
DEPTH, 8, number of entries (power of two, at least 2)
WIDTH, 8, data bits per entry
THRESH, 4, fill level at or above which rx_int asserts (1..DEPTH)
TIMEOUT, 32, idle cycles with a non-empty FIFO before rx_tmo asserts (at least 2)

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  FIFO enable; when 0, push and pop are ignored
push  in  1  receiver has a completed byte this cycle (single-cycle pulse)
data_in  in  WIDTH  received byte, valid with push
fe_in  in  1  framing-error tag for data_in, valid with push
pop  in  1  CPU read strobe; consumes the head entry
clr_ovr  in  1  clears the sticky overrun flag
data_out  out  WIDTH  head entry data; 0 when empty
fe_out  out  1  head entry framing-error tag; 0 when empty
rxff  out  1  FIFO full (count == DEPTH)
rxfe  out  1  FIFO empty (count == 0)
ovr  out  1  sticky overrun flag
count  out  log2(DEPTH)+1  current occupancy
rx_int  out  1  count >= THRESH
rx_tmo  out  1  idle timeout with data pending

Behaviour:
- Storage: DEPTH x (WIDTH+1) circular array with write pointer, read pointer and count register. Pointers wrap from DEPTH-1 to 0.
- Reset (reset=0, asynchronous): pointers=0, count=0, ovr=0, idle counter=0, rx_tmo=0, storage cleared to 0. Resulting outputs: rxfe=1, rxff=0, rx_int=0, data_out=0, fe_out=0. Reset asserted mid-stream discards all contents immediately, without waiting for a clock edge.
- Push is effective when en & push & (!rxff | pop_eff). The entry is written at the write pointer and the write pointer increments.
- Pop is effective (pop_eff) when en & pop & !rxfe. The read pointer increments.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Push when full and no effective pop: the byte is dropped, contents are unchanged, and ovr is set on that edge.
- Push and pop together when full: both take effect, count stays DEPTH, no overrun.
- Push and pop together when empty: the pop is ignored and the push is accepted; count becomes 1.
- Read latency: data_out and fe_out are combinational from the head entry. A byte pushed at edge N is visible immediately after edge N, and pop at edge N+1 consumes it.
- ovr clears on the first edge with clr_ovr=1. If clr_ovr and an overrun occur on the same edge, set wins and ovr stays 1.
- clr_ovr acts regardless of en.
- en=0: push and pop are ignored, and ovr is not set. The idle counter is held.
- rxff, rxfe and rx_int are combinational from count.
- Idle counter:
  - Resets to 0 on any effective push or pop, and whenever the FIFO is empty.
  - Otherwise, with en=1 and the FIFO non-empty, it increments each cycle and saturates at TIMEOUT.
  - rx_tmo is registered: it is 1 while the counter == TIMEOUT and clears on the edge after the next effective push or pop, or when the FIFO becomes empty.
- Status update: all status changes take effect one edge after the causing strobe, except rx_tmo clear as specified above.

Test Plan:
- Reset then push 0x24, 0x32, 0x63 on consecutive edges -> count=3, data_out=0x24, rxfe=0, rx_int=0. Three pops return 0x24, 0x32, 0x63 in order, ending with rxfe=1 and data_out=0.
- Push 8 bytes 0x10..0x17 -> rxff=1, rx_int=1 from the 4th push onward. A 9th push of 0xAA -> ovr=1, count=8, and a subsequent pop returns 0x10 (0xAA is never seen). clr_ovr -> ovr=0.
- Full FIFO with push 0x55 and pop together -> count stays 8, no ovr. After 8 pops the final data_out is 0x55. This also checks pointer wrap-around.
- Empty FIFO with push 0x3C and pop together -> count=1, data_out=0x3C.
- Push 0x81 with fe_in=1, then 0x82 with fe_in=0 -> fe_out=1 with 0x81 at head, fe_out=0 after the pop.
- One byte held with no traffic for 32 cycles -> rx_tmo=1. A pop clears it. Asserting reset low mid-wait clears rx_tmo and count asynchronously. With en=0, push/pop are ignored and the idle counter is frozen.
